// File: rtl/grv_stats_monitor_pkg.sv
// rtl/grv_stats_monitor_pkg.sv - shared constants and state encoding for the Gaussian RNG statistics monitor
package grv_stats_monitor_pkg;

    // Default sample width; the Box-Muller generator uses the same value.
    localparam int GRV_DATA_W = 16;
    localparam int GRV_LOG2_N = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } grv_state_e;

endpackage

// File: rtl/grv_stats_monitor_if.sv
// rtl/grv_stats_monitor_if.sv - sample stream, control and result bundle of the statistics monitor
// master: generator/consumer side (drives start, grv1/grv2/outputvalid, result_ready)
// slave : monitor side (drives busy, result_valid and the result fields)
interface grv_stats_monitor_if
    import grv_stats_monitor_pkg::*;
#(
    parameter int DATA_W = GRV_DATA_W,
    parameter int LOG2_N = GRV_LOG2_N
) ();

    logic                              start;
    logic signed [DATA_W-1:0]          grv1;
    logic signed [DATA_W-1:0]          grv2;
    logic                              outputvalid;
    logic                              busy;
    logic                              result_valid;
    logic                              result_ready;
    logic signed [DATA_W+LOG2_N-1:0]   sum1;
    logic signed [DATA_W+LOG2_N-1:0]   sum2;
    logic        [2*DATA_W+LOG2_N-1:0] sumsq;
    logic signed [DATA_W-1:0]          min_val;
    logic signed [DATA_W-1:0]          max_val;

    modport master (
        output start, grv1, grv2, outputvalid, result_ready,
        input  busy, result_valid, sum1, sum2, sumsq, min_val, max_val
    );

    modport slave (
        input  start, grv1, grv2, outputvalid, result_ready,
        output busy, result_valid, sum1, sum2, sumsq, min_val, max_val
    );

endinterface

// File: rtl/grv_stats_monitor_square_stage.sv
// rtl/grv_stats_monitor_square_stage.sv - registered grv1^2 + grv2^2 per accepted pair, 1 clk latency
// Ports: clk, reset (sync, active-high), valid_in/a/b (signed samples),
//        valid_out/sq_sum (unsigned sum of both squares, one cycle later)
module grv_stats_monitor_square_stage #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic                     valid_out,
    output logic [2*DATA_W-1:0]      sq_sum
);

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] sq_a;
    logic signed [2*DATA_W-1:0] sq_b;
    logic                       valid_d, valid_q;
    logic [2*DATA_W-1:0]        sq_sum_d, sq_sum_q;

    // Two full-width squares of -2**(DATA_W-1) sum to 2**(2*DATA_W-1), so the
    // pair sum needs all 2*DATA_W bits even though each square needs one less.
    always_comb begin
        a_ext    = {{DATA_W{a[DATA_W-1]}}, a};
        b_ext    = {{DATA_W{b[DATA_W-1]}}, b};
        sq_a     = a_ext * a_ext;
        sq_b     = b_ext * b_ext;
        valid_d  = valid_in;
        sq_sum_d = sq_sum_q;
        if (valid_in) begin
            sq_sum_d = $unsigned(sq_a) + $unsigned(sq_b);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            sq_sum_q <= '0;
        end else begin
            valid_q  <= valid_d;
            sq_sum_q <= sq_sum_d;
        end
    end

    assign valid_out = valid_q;
    assign sq_sum    = sq_sum_q;

endmodule

// File: rtl/grv_stats_monitor.sv
// rtl/grv_stats_monitor.sv - windowed sum / sum-of-squares / min / max of Gaussian RNG sample pairs
// Ports: clk, reset (sync, active-high), bus (slave): start, grv1, grv2, outputvalid in;
//        busy, result_valid/result_ready handshake, sum1, sum2, sumsq, min_val, max_val out
module grv_stats_monitor
    import grv_stats_monitor_pkg::*;
#(
    parameter int DATA_W = GRV_DATA_W,
    parameter int LOG2_N = GRV_LOG2_N
) (
    input  logic           clk,
    input  logic           reset,
    grv_stats_monitor_if.slave bus
);

    localparam int SUM_W = DATA_W + LOG2_N;
    localparam int SQ_W  = 2 * DATA_W + LOG2_N;
    localparam logic [LOG2_N:0]        LAST_CNT = {1'b0, {LOG2_N{1'b1}}};
    localparam logic signed [DATA_W-1:0] S_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] S_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    grv_state_e                state_d, state_q;
    logic [LOG2_N:0]           cnt_d, cnt_q;
    logic signed [SUM_W-1:0]   sum1_d, sum1_q, sum2_d, sum2_q;
    logic [SQ_W-1:0]           sumsq_d, sumsq_q;
    logic signed [DATA_W-1:0]  min_d, min_q, max_d, max_q;
    logic                      busy_d, busy_q, result_valid_d, result_valid_q;
    logic                      accept, clear;
    logic                      sq_valid;
    logic [2*DATA_W-1:0]       sq_sum;

    // Samples only count while accumulating; once the last pair is taken the
    // state leaves ACCUM, which is what makes later strobes ignored.
    assign accept = (state_q == ST_ACCUM) && bus.outputvalid;

    grv_stats_monitor_square_stage #(.DATA_W(DATA_W)) u_square (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (accept),
        .a         (bus.grv1),
        .b         (bus.grv2),
        .valid_out (sq_valid),
        .sq_sum    (sq_sum)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum1_d  = sum1_q;
        sum2_d  = sum2_q;
        sumsq_d = sumsq_q;
        min_d   = min_q;
        max_d   = max_q;
        clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    clear   = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    sum1_d = sum1_q + {{LOG2_N{bus.grv1[DATA_W-1]}}, bus.grv1};
                    sum2_d = sum2_q + {{LOG2_N{bus.grv2[DATA_W-1]}}, bus.grv2};
                    if (bus.grv1 < min_d) min_d = bus.grv1;
                    if (bus.grv2 < min_d) min_d = bus.grv2;
                    if (bus.grv1 > max_d) max_d = bus.grv1;
                    if (bus.grv2 > max_d) max_d = bus.grv2;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.result_ready) begin
                    // Back-to-back windows: start alongside result_ready skips IDLE.
                    clear   = bus.start;
                    state_d = bus.start ? ST_ACCUM : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Square stage trails the sums by one cycle; its last output lands in FLUSH.
        if (sq_valid) begin
            sumsq_d = sumsq_q + {{LOG2_N{1'b0}}, sq_sum};
        end

        if (clear) begin
            cnt_d   = '0;
            sum1_d  = '0;
            sum2_d  = '0;
            sumsq_d = '0;
            min_d   = S_MAX;
            max_d   = S_MIN;
        end

        busy_d         = (state_d == ST_ACCUM) || (state_d == ST_FLUSH);
        result_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            sum1_q         <= '0;
            sum2_q         <= '0;
            sumsq_q        <= '0;
            min_q          <= '0;
            max_q          <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sum1_q         <= sum1_d;
            sum2_q         <= sum2_d;
            sumsq_q        <= sumsq_d;
            min_q          <= min_d;
            max_q          <= max_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.sum1         = sum1_q;
    assign bus.sum2         = sum2_q;
    assign bus.sumsq        = sumsq_q;
    assign bus.min_val      = min_q;
    assign bus.max_val      = max_q;

endmodule

// File: tb/tb_grv_stats_monitor.sv
// tb/tb_grv_stats_monitor.sv - randomized self-checking bench for grv_stats_monitor
module tb_grv_stats_monitor;
    import grv_stats_monitor_pkg::*;

    localparam int DW   = GRV_DATA_W;
    localparam int LN_S = 2;
    localparam int LN_L = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grv_stats_monitor_if #(.DATA_W(DW), .LOG2_N(LN_S)) s_if ();
    grv_stats_monitor_if #(.DATA_W(DW), .LOG2_N(LN_L)) l_if ();

    grv_stats_monitor #(.DATA_W(DW), .LOG2_N(LN_S)) u_dut_s (.clk(clk), .reset(reset), .bus(s_if.slave));
    grv_stats_monitor #(.DATA_W(DW), .LOG2_N(LN_L)) u_dut_l (.clk(clk), .reset(reset), .bus(l_if.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: statistics of the pairs queued for the current window.
    logic signed [DW-1:0] q1[$];
    logic signed [DW-1:0] q2[$];
    longint e_s1, e_s2, e_sq, e_mn, e_mx;

    task automatic calc_exp();
        longint a, b;
        e_s1 = 0; e_s2 = 0; e_sq = 0; e_mn = 32767; e_mx = -32768;
        foreach (q1[i]) begin
            a = q1[i];
            b = q2[i];
            e_s1 += a;
            e_s2 += b;
            e_sq += a * a + b * b;
            if (a < e_mn) e_mn = a;
            if (b < e_mn) e_mn = b;
            if (a > e_mx) e_mx = a;
            if (b > e_mx) e_mx = b;
        end
    endtask

    // mode 0: (k,-k) ramp, mode 1: all most-negative, mode 2: random with occasional extremes
    task automatic gen_pairs(input int n, input int mode);
        q1.delete();
        q2.delete();
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: begin q1.push_back(16'(i + 1)); q2.push_back(-16'(i + 1)); end
                1: begin q1.push_back(16'h8000); q2.push_back(16'h8000); end
                default: begin
                    q1.push_back(($urandom_range(15, 0) == 0) ? 16'h8000 : 16'($urandom));
                    q2.push_back(($urandom_range(15, 0) == 0) ? 16'h7FFF : 16'($urandom));
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_s();
        s_if.start = 1'b1;
        tick();
        s_if.start = 1'b0;
        check_val("s_start_busy", s_if.busy, 1);
        check_val("s_start_sum1", s_if.sum1, 0);
        check_val("s_start_min", s_if.min_val, 32767);
        check_val("s_start_max", s_if.max_val, -32768);
    endtask

    task automatic send_s(input int gap_max, input bit extra);
        int gap;
        for (int i = 0; i < q1.size(); i++) begin
            gap = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
            repeat (gap) begin
                s_if.outputvalid = 1'b0;
                s_if.grv1 = 16'($urandom);
                s_if.grv2 = 16'($urandom);
                tick();
                check_val("s_busy_gap", s_if.busy, 1);
            end
            s_if.outputvalid = 1'b1;
            s_if.grv1 = q1[i];
            s_if.grv2 = q2[i];
            tick();
            if (i != q1.size() - 1) check_val("s_busy_acc", s_if.busy, 1);
        end
        s_if.outputvalid = extra;
        s_if.grv1 = 16'h1234;
        s_if.grv2 = 16'h4321;
        check_val("s_rv_flush", s_if.result_valid, 0);
        check_val("s_busy_flush", s_if.busy, 1);
        tick();
        s_if.outputvalid = 1'b0;
        check_val("s_rv_hold", s_if.result_valid, 1);
        check_val("s_busy_hold", s_if.busy, 0);
    endtask

    task automatic results_s(input string tag);
        calc_exp();
        check_val({tag, "_sum1"}, s_if.sum1, e_s1);
        check_val({tag, "_sum2"}, s_if.sum2, e_s2);
        check_val({tag, "_sumsq"}, s_if.sumsq, e_sq);
        check_val({tag, "_min"}, s_if.min_val, e_mn);
        check_val({tag, "_max"}, s_if.max_val, e_mx);
    endtask

    task automatic release_s();
        s_if.result_ready = 1'b1;
        tick();
        s_if.result_ready = 1'b0;
        check_val("s_rv_release", s_if.result_valid, 0);
        check_val("s_busy_release", s_if.busy, 0);
    endtask

    int   l_rv_rises = 0;
    logic l_rv_prev  = 1'b0;
    always @(negedge clk) begin
        if (l_if.result_valid && !l_rv_prev) l_rv_rises++;
        l_rv_prev = l_if.result_valid;
    end

    task automatic window_l(input int idx);
        gen_pairs(1 << LN_L, 2);
        l_if.start = 1'b1;
        tick();
        l_if.start = 1'b0;
        foreach (q1[i]) begin
            if ($urandom_range(1, 0) == 1) begin
                l_if.outputvalid = 1'b0;
                tick();
            end
            l_if.outputvalid = 1'b1;
            l_if.grv1 = q1[i];
            l_if.grv2 = q2[i];
            tick();
        end
        l_if.outputvalid = 1'b1;
        check_val("l_rv_flush", l_if.result_valid, 0);
        tick();
        l_if.outputvalid = 1'b0;
        check_val("l_rv_hold", l_if.result_valid, 1);
        calc_exp();
        check_val("l_sum1", l_if.sum1, e_s1);
        check_val("l_sum2", l_if.sum2, e_s2);
        check_val("l_sumsq", l_if.sumsq, e_sq);
        check_val("l_min", l_if.min_val, e_mn);
        check_val("l_max", l_if.max_val, e_mx);
        l_if.result_ready = 1'b1;
        tick();
        l_if.result_ready = 1'b0;
        tick();
        check_val("l_rv_once", l_rv_rises, idx + 1);
    endtask

    initial begin
        reset = 1'b1;
        s_if.start = 0; s_if.grv1 = 0; s_if.grv2 = 0; s_if.outputvalid = 0; s_if.result_ready = 0;
        l_if.start = 0; l_if.grv1 = 0; l_if.grv2 = 0; l_if.outputvalid = 0; l_if.result_ready = 0;
        tick();
        tick();
        reset = 1'b0;
        check_val("rst_sum1", s_if.sum1, 0);
        check_val("rst_sum2", s_if.sum2, 0);
        check_val("rst_sumsq", s_if.sumsq, 0);
        check_val("rst_min", s_if.min_val, 0);
        check_val("rst_max", s_if.max_val, 0);
        check_val("rst_busy", s_if.busy, 0);
        check_val("rst_rv", s_if.result_valid, 0);
        check_val("rst_l_rv", l_if.result_valid, 0);

        // Ramp pairs back-to-back
        gen_pairs(4, 0);
        start_s();
        send_s(0, 1'b0);
        results_s("t1");
        release_s();

        // Same pairs with gaps and a stray 5th pair during FLUSH
        start_s();
        send_s(3, 1'b1);
        results_s("t2");
        release_s();

        // Most-negative samples everywhere
        gen_pairs(4, 1);
        start_s();
        send_s(1, 1'b0);
        results_s("t3");

        // Hold with stray start/strobes, then release+start together
        for (int i = 0; i < 10; i++) begin
            s_if.start = 1'($urandom);
            s_if.outputvalid = 1'($urandom);
            s_if.grv1 = 16'($urandom);
            tick();
            results_s("t4_hold");
            check_val("t4_rv", s_if.result_valid, 1);
        end
        s_if.outputvalid = 1'b0;
        s_if.start = 1'b1;
        s_if.result_ready = 1'b1;
        tick();
        s_if.start = 1'b0;
        s_if.result_ready = 1'b0;
        check_val("t4_rv_drop", s_if.result_valid, 0);
        check_val("t4_busy", s_if.busy, 1);
        check_val("t4_sum1_clr", s_if.sum1, 0);
        check_val("t4_sumsq_clr", s_if.sumsq, 0);

        // Reset after two pairs of the new window
        gen_pairs(4, 2);
        for (int i = 0; i < 2; i++) begin
            s_if.outputvalid = 1'b1;
            s_if.grv1 = q1[i];
            s_if.grv2 = q2[i];
            tick();
        end
        s_if.outputvalid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t5_sum1", s_if.sum1, 0);
        check_val("t5_sum2", s_if.sum2, 0);
        check_val("t5_sumsq", s_if.sumsq, 0);
        check_val("t5_min", s_if.min_val, 0);
        check_val("t5_max", s_if.max_val, 0);
        check_val("t5_busy", s_if.busy, 0);
        check_val("t5_rv", s_if.result_valid, 0);
        tick();
        check_val("t5_idle_busy", s_if.busy, 0);
        start_s();
        send_s(2, 1'b0);
        results_s("t5_new");
        release_s();

        // Several random short windows
        for (int w = 0; w < 4; w++) begin
            gen_pairs(4, 2);
            start_s();
            send_s(w, w[0]);
            results_s("rnd");
            release_s();
        end

        // Full-size windows on the 1024-pair instance
        for (int w = 0; w < 2; w++) window_l(w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
